ifetch_line_buffer: RTL
=======================

IFETCH_LINE_BUFFER -- requirements
Module: ifetch_line_buffer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port stall, input, 1 bit: downstream decode cannot accept the current instruction.
REQ-004 SHALL have port redirect, input, 1 bit: control-flow change requested this cycle.
REQ-005 SHALL have port redirect_pc, input, 16 bits: new fetch PC (lc3b_word).
REQ-006 SHALL have port mem_read, output, 1 bit: line read request to I-cache.
REQ-007 SHALL have port mem_address, output, 16 bits: line-aligned read address, bits [3:0] = 0.
REQ-008 SHALL have port mem_rdata, input, 128 bits: returned line (lc3b_datbus).
REQ-009 SHALL have port mem_resp, input, 1 bit: read complete, mem_rdata valid this cycle.
REQ-010 SHALL have port instr_valid, output, 1 bit: instr/instr_pc valid for decode.
REQ-011 SHALL have port instr, output, 16 bits: instruction word at instr_pc.
REQ-012 SHALL have port instr_pc, output, 16 bits: PC of instr, bit 0 always 0.

Function
REQ-013 SHALL hold registers: pc[15:0], line[127:0], tag[11:0], line_valid, state.
REQ-014 SHALL implement states FETCH, HOLD, DISCARD.
REQ-015 SHALL, in FETCH and DISCARD, drive mem_read=1 and mem_address={pc[15:4],4'b0} (DISCARD: address of the abandoned request), held stable until mem_resp.
REQ-016 SHALL drive mem_read=0 in HOLD.
REQ-017 SHALL, in FETCH on mem_resp without redirect, capture line=mem_rdata, tag=pc[15:4], line_valid=1, enter HOLD; instr_valid asserts the following cycle (one cycle after mem_resp).
REQ-018 SHALL drive instr_valid=1 only in HOLD with line_valid=1 and tag==pc[15:4]; otherwise 0.
REQ-019 SHALL select instr = line[16*k+15 : 16*k] with k=pc[3:1]; instr_pc=pc.
REQ-020 SHALL advance pc by 2 when instr_valid=1, stall=0, redirect=0.
REQ-021 SHALL, on advance with pc[3:1]=3'b111, enter FETCH for the next line; pc wraps 16'hFFFE -> 16'h0000.
REQ-022 SHALL hold pc, instr, instr_pc stable while stall=1 and redirect=0.
REQ-023 SHALL give redirect priority over stall and advance: pc <= {redirect_pc[15:1],1'b0}.
REQ-024 SHALL, on redirect in HOLD, stay in HOLD if redirect_pc[15:4]==tag with line_valid=1 (instr_valid next cycle, no memory access), else enter FETCH.
REQ-025 SHALL, on redirect in FETCH without mem_resp that cycle, enter DISCARD keeping the old mem_address until mem_resp.
REQ-026 SHALL, on redirect in FETCH coinciding with mem_resp, discard mem_rdata (line_valid=0) and enter FETCH for the new pc.
REQ-027 SHALL, in DISCARD on mem_resp, drop mem_rdata and enter FETCH for the current pc; redirect in DISCARD only updates pc.
REQ-028 SHALL ignore mem_resp in HOLD.
REQ-029 SHALL clear line_valid whenever a new line request is issued.

Reset
REQ-030 SHALL, on reset_n=0, immediately set pc=16'h0000, line_valid=0, tag=0, line=0, state=FETCH.
REQ-031 SHALL drive instr_valid=0, instr_pc=16'h0000, instr=16'h0000 during reset; mem_read=1, mem_address=16'h0000 after reset_n rises.
REQ-032 SHALL, on reset mid-request, abandon the request with no DISCARD state; the next mem_resp is taken as the response to the post-reset request.

Verification
REQ-033 Reset release, mem_resp after 3 cycles with line words 16'h1000..16'h1007 -> instr_valid next cycle, instr_pc 0x0000..0x000E, instr 0x1000..0x1007 over 8 consecutive cycles, then mem_read=1 with mem_address=0x0010.
REQ-034 stall=1 for 4 cycles at instr_pc=0x0006 -> instr_pc and instr unchanged, mem_read=0.
REQ-035 redirect_pc=0x000B in HOLD on line 0x0000 -> next cycle instr_pc=0x000A, instr_valid=1, no mem_read.
REQ-036 redirect_pc=0x4020 while FETCH of 0x0010 outstanding -> mem_address stays 0x0010 until mem_resp, data dropped, then mem_address=0x4020, instr_valid only after second mem_resp.
REQ-037 redirect and mem_resp same cycle -> line not used, next cycle mem_read=1 at new line address.
REQ-038 Advance at pc=0xFFFE -> pc=0x0000, FETCH of line 0x0000; reset_n=0 mid-request -> outputs at reset values within the same cycle.

Source files
------------

// File: rtl/ifetch_line_buffer.sv
// Instruction fetch line buffer: holds one 128-bit I-cache line and
// streams its 16-bit words to decode, refilling on line exhaustion or redirect.
module ifetch_line_buffer (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         stall,
    input  logic         redirect,
    input  logic [15:0]  redirect_pc,
    output logic         mem_read,
    output logic [15:0]  mem_address,
    input  logic [127:0] mem_rdata,
    input  logic         mem_resp,
    output logic         instr_valid,
    output logic [15:0]  instr,
    output logic [15:0]  instr_pc
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t         state;
    logic [15:0]    pc;
    logic [127:0]   line;
    logic [11:0]    tag;
    logic           line_valid;
    logic [11:0]    req_tag;

    logic [15:0]    new_pc;
    logic [6:0]     word_lsb;
    logic           line_hit;
    logic           advance;

    assign new_pc   = {redirect_pc[15:1], 1'b0};
    assign word_lsb = {pc[3:1], 4'b0000};
    assign line_hit = line_valid && (redirect_pc[15:4] == tag);

    assign instr_valid = (state == HOLD) && line_valid && (tag == pc[15:4]);
    assign instr       = line[word_lsb +: 16];
    assign instr_pc    = pc;
    assign advance     = instr_valid && !stall && !redirect;

    // DISCARD keeps presenting the abandoned request's address until it returns
    assign mem_read    = (state != HOLD);
    assign mem_address = (state == DISCARD) ? {req_tag, 4'b0000}
                                            : {pc[15:4], 4'b0000};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FETCH;
            pc         <= 16'h0000;
            line       <= '0;
            tag        <= '0;
            line_valid <= 1'b0;
            req_tag    <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    req_tag <= pc[15:4];
                    if (redirect) begin
                        pc         <= new_pc;
                        line_valid <= 1'b0;
                        state      <= mem_resp ? FETCH : DISCARD;
                    end else if (mem_resp) begin
                        line       <= mem_rdata;
                        tag        <= pc[15:4];
                        line_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc <= new_pc;
                        if (!line_hit) begin
                            line_valid <= 1'b0;
                            state      <= FETCH;
                        end
                    end else if (advance) begin
                        pc <= pc + 16'd2;
                        if (pc[3:1] == 3'b111) begin
                            line_valid <= 1'b0;
                            state      <= FETCH;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        pc <= new_pc;
                    end
                    if (mem_resp) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
